// File: rtl/spi_master_tx_ml.sv
// spi_master_tx_ml: SPI transmit shifter with 1/2/4 lanes, a bit-count target, word chaining and underrun abort.
module spi_master_tx_ml #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              tx_edge,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              counter_in_upd,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [3:0]        sdo,
  output logic [3:0]        sdo_oe,
  output logic              clk_en_o,
  output logic              tx_done,
  output logic              underrun
);
  typedef enum logic {IDLE, TRANSMIT} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  shift_cnt_q, word_cnt_q, target_q, target_in;
  logic [1:0]        mode_q, lg_q, lg_in;
  logic              lsb_q, underrun_q;
  logic              tx, go, edge_act, word_last, word_bnd, starve;
  logic [3:0]        msb_nib, lsb_nib, lanes_out;

  // log2 of the lane count; mode 11 falls back to single lane
  function automatic logic [1:0] lg(input logic [1:0] m);
    return m == 2'b01 ? 2'd1 : m == 2'b10 ? 2'd2 : 2'd0;
  endfunction

  always_comb begin
    tx         = state_q == TRANSMIT;
    lg_q       = lg(mode_q);
    lg_in      = lg(mode);
    target_in  = counter_in >> lg_in;
    go         = en && data_valid;
    edge_act   = tx && tx_edge;
    tx_done    = edge_act && shift_cnt_q == target_q - 1'b1;
    word_last  = word_cnt_q == CNT_W'((DATA_W >> lg_q) - 1);
    word_bnd   = edge_act && word_last && !tx_done;
    starve     = word_bnd && !data_valid;
    data_ready = rstn && ((!tx && go) || (tx_done && go) || (word_bnd && data_valid));
    clk_en_o   = tx && !(tx_done && !go) && !starve;
    msb_nib    = shreg_q[DATA_W-1 -: 4];
    lsb_nib    = shreg_q[3:0];
    lanes_out  = lsb_q ? (lg_q == 2'd2 ? lsb_nib : lg_q == 2'd1 ? {2'b0, lsb_nib[1:0]} : {3'b0, lsb_nib[0]})
                       : (lg_q == 2'd2 ? msb_nib : lg_q == 2'd1 ? {2'b0, msb_nib[3:2]} : {3'b0, msb_nib[3]});
    sdo        = tx ? lanes_out : 4'b0;
    sdo_oe     = !tx ? 4'b0 : lg_q == 2'd2 ? 4'b1111 : lg_q == 2'd1 ? 4'b0011 : 4'b0001;
    shreg_d    = lsb_q ? shreg_q >> (1 << lg_q) : shreg_q << (1 << lg_q);
    underrun   = underrun_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      shift_cnt_q <= '0;
      word_cnt_q  <= '0;
      target_q    <= CNT_W'(8);
      mode_q      <= 2'b00;
      lsb_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      underrun_q <= starve;
      if (!tx) begin
        if (counter_in_upd && target_in != '0) target_q <= target_in;
        if (go) begin
          state_q     <= TRANSMIT;
          shreg_q     <= data;
          shift_cnt_q <= '0;
          word_cnt_q  <= '0;
          mode_q      <= mode;
          lsb_q       <= lsb_first;
        end
      end else if (tx_edge) begin
        shreg_q     <= shreg_d;
        shift_cnt_q <= shift_cnt_q + 1'b1;
        word_cnt_q  <= word_cnt_q + 1'b1;
        if (tx_done) begin
          shift_cnt_q <= '0;
          word_cnt_q  <= '0;
          if (go) shreg_q <= data;
          else state_q <= IDLE;
        end else if (word_last) begin
          if (data_valid) begin
            shreg_q    <= data;
            word_cnt_q <= '0;
          end else state_q <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_master_tx_ml.sv
// tb_spi_master_tx_ml: directed vector table plus multi-cycle sequences for underrun, chaining and reset.
module tb_spi_master_tx_ml;
  logic        clk = 1'b0, rstn;
  logic        en, tx_edge, lsb_first, counter_in_upd, data_valid;
  logic [1:0]  mode;
  logic [15:0] counter_in;
  logic [31:0] data;
  logic        data_ready, clk_en_o, tx_done, underrun;
  logic [3:0]  sdo, sdo_oe;
  int          checks = 0, errors = 0;

  typedef struct {
    logic        en, te;
    logic [1:0]  md;
    logic        lsb;
    logic [15:0] cnt;
    logic        upd;
    logic [31:0] d;
    logic        dv;
    logic [11:0] exp;
  } vec_t;
  vec_t vq[$];

  spi_master_tx_ml dut (
    .clk(clk), .rstn(rstn), .en(en), .tx_edge(tx_edge), .mode(mode), .lsb_first(lsb_first),
    .counter_in(counter_in), .counter_in_upd(counter_in_upd), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .sdo(sdo), .sdo_oe(sdo_oe), .clk_en_o(clk_en_o), .tx_done(tx_done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // expected-output word: {data_ready, sdo, sdo_oe, clk_en_o, tx_done, underrun}
  function automatic logic [11:0] o(input logic r, input logic [3:0] s, input logic [3:0] e,
                                    input logic c, input logic dn, input logic u);
    return {r, s, e, c, dn, u};
  endfunction

  function automatic vec_t mk(input logic e, input logic t, input logic [1:0] m, input logic l,
                              input logic [15:0] c, input logic up, input logic [31:0] dd,
                              input logic v, input logic [11:0] x);
    vec_t r;
    r.en = e; r.te = t; r.md = m; r.lsb = l; r.cnt = c; r.upd = up; r.d = dd; r.dv = v; r.exp = x;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h ({rdy,sdo,oe,cke,done,und})", nm, act, exp);
    end
  endtask

  // called at posedge+1: drive, settle, compare, advance one clock
  task automatic apply(input vec_t v, input string nm);
    en = v.en; tx_edge = v.te; mode = v.md; lsb_first = v.lsb;
    counter_in = v.cnt; counter_in_upd = v.upd; data = v.d; data_valid = v.dv;
    #2;
    chk(nm, {data_ready, sdo, sdo_oe, clk_en_o, tx_done, underrun}, v.exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] a5;
    logic [11:0] z;
    a5 = 8'hA5;
    z  = 12'h000;
    // single lane, MSB-first, default target 8
    vq.push_back(mk(1, 0, 2'b00, 0, 0, 0, 32'hA500_0000, 1, o(1, 0, 0, 0, 0, 0)));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 0, o(0, {3'b0, a5[7-i]}, 4'h1, i != 7, i == 7, 0)));
    vq.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, z));
    // quad: target 32>>2; mode and counter_in_upd changes mid-transfer must be ignored
    vq.push_back(mk(0, 0, 2'b10, 0, 32, 1, 0, 0, z));
    vq.push_back(mk(1, 0, 2'b10, 0, 0, 0, 32'h1234_5678, 1, o(1, 0, 0, 0, 0, 0)));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0, 1, i < 4 ? 2'b10 : 2'b00, 0, 4, i == 2, 0, 0,
                      o(0, 4'(i + 1), 4'hF, i != 7, i == 7, 0)));
    vq.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, z));
    // dual LSB-first: target 8>>1, with one idle (no-edge) cycle mid-transfer
    vq.push_back(mk(0, 0, 2'b01, 0, 8, 1, 0, 0, z));
    vq.push_back(mk(1, 0, 2'b01, 1, 0, 0, 32'h0000_001B, 1, o(1, 0, 0, 0, 0, 0)));
    vq.push_back(mk(0, 1, 2'b01, 1, 0, 0, 0, 0, o(0, 3, 4'h3, 1, 0, 0)));
    vq.push_back(mk(0, 0, 2'b01, 1, 0, 0, 0, 0, o(0, 2, 4'h3, 1, 0, 0)));
    vq.push_back(mk(0, 1, 2'b01, 1, 0, 0, 0, 0, o(0, 2, 4'h3, 1, 0, 0)));
    vq.push_back(mk(0, 1, 2'b01, 1, 0, 0, 0, 0, o(0, 1, 4'h3, 1, 0, 0)));
    vq.push_back(mk(0, 1, 2'b01, 1, 0, 0, 0, 0, o(0, 0, 4'h3, 0, 1, 0)));
    vq.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, z));

    rstn = 1'b0; en = 0; tx_edge = 0; mode = 0; lsb_first = 0;
    counter_in = 0; counter_in_upd = 0; data = 0; data_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {data_ready, sdo, sdo_oe, clk_en_o, tx_done, underrun}, z);
    rstn = 1'b1;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("vec%0d", i));

    // underrun: target 64 single lane, second word missing at edge 32
    apply(mk(0, 0, 2'b00, 0, 64, 1, 0, 0, z), "ur_tgt");
    apply(mk(1, 0, 2'b00, 0, 0, 0, 32'hFFFF_FFFF, 1, o(1, 0, 0, 0, 0, 0)), "ur_start");
    for (int i = 0; i < 31; i++)
      apply(mk(1, 1, 2'b00, 0, 0, 0, 0, 0, o(0, 1, 4'h1, 1, 0, 0)), $sformatf("ur_edge%0d", i));
    apply(mk(1, 1, 2'b00, 0, 0, 0, 0, 0, o(0, 1, 4'h1, 0, 0, 0)), "ur_starve");
    apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 1)), "ur_pulse");
    apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, z), "ur_clear");

    // chaining: three 8-bit words back to back, data_valid dropped for the last
    apply(mk(0, 0, 2'b00, 0, 8, 1, 0, 0, z), "ch_tgt");
    apply(mk(1, 0, 2'b00, 0, 0, 0, 32'hA500_0000, 1, o(1, 0, 0, 0, 0, 0)), "ch_start");
    for (int w = 0; w < 3; w++)
      for (int e = 0; e < 8; e++)
        apply(mk(1, 1, 2'b00, 0, 0, 0, 32'hFF00_0000, w < 2,
                 o(e == 7 && w < 2, {3'b0, w == 0 ? a5[7-e] : 1'b1}, 4'h1, !(e == 7 && w == 2), e == 7, 0)),
              $sformatf("ch_w%0d_e%0d", w, e));
    apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, z), "ch_idle");

    // reset mid-transfer in quad mode with target 16, then confirm target back to 8
    apply(mk(0, 0, 2'b10, 0, 64, 1, 0, 0, z), "rs_tgt");
    apply(mk(1, 0, 2'b10, 0, 0, 0, 32'h1234_5678, 1, o(1, 0, 0, 0, 0, 0)), "rs_start");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 2'b01, 0, 0, 0, 0, 0, o(0, 4'(i + 1), 4'hF, 1, 0, 0)), $sformatf("rs_edge%0d", i));
    en = 1; data_valid = 1; tx_edge = 1; rstn = 1'b0;
    #2;
    chk("rs_async", {data_ready, sdo, sdo_oe, clk_en_o, tx_done, underrun}, z);
    @(posedge clk); #1;
    chk("rs_hold", {data_ready, sdo, sdo_oe, clk_en_o, tx_done, underrun}, z);
    en = 0; data_valid = 0; tx_edge = 0; rstn = 1'b1;
    apply(mk(1, 0, 2'b00, 0, 0, 0, 0, 1, o(1, 0, 0, 0, 0, 0)), "rs_restart");
    for (int i = 0; i < 8; i++)
      apply(mk(0, 1, 2'b00, 0, 0, 0, 0, 0, o(0, 0, 4'h1, i != 7, i == 7, 0)), $sformatf("rs_t8_%0d", i));
    apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, z), "rs_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
